pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage RV32I pipeline. Drives the fetch
//  unit's stall/dnpc/dnpc_flag inputs and ID/EX stall and flush controls. Resolves
//  load-use hazards, taken-branch redirects and data-memory wait states. Holds a redirect
//  that arrives during a memory wait until the wait ends. Sits beside the datapath; one
//  instance per core.
// PARAMETERS
//  LU_STALL_CYCLES  1   stall cycles inserted per load-use hazard (1..7)
//  WDT_W            4   width of memory-wait watchdog counter
// PORTS
//  clock         in   1   core clock
//  reset_n       in   1   synchronous reset, active low
//  id_rs1        in   5   ID-stage rs1 index
//  id_rs2        in   5   ID-stage rs2 index
//  id_rs1_used   in   1   ID instruction reads rs1
//  id_rs2_used   in   1   ID instruction reads rs2
//  ex_valid      in   1   EX stage holds a real (non-bubble) instruction
//  ex_is_load    in   1   EX instruction is a load
//  ex_rd         in   5   EX destination index
//  ex_br_taken   in   1   EX resolved taken branch/jump
//  ex_br_target  in   32  EX redirect target
//  dmem_req      in   1   MEM stage has an outstanding data access
//  dmem_ack      in   1   data access completes this cycle
//  stall         out  1   fetch PC hold (to fetch unit stall)
//  dnpc          out  32  redirect PC (to fetch unit)
//  dnpc_flag     out  1   redirect valid (to fetch unit)
//  id_stall      out  1   hold IF/ID register
//  flush_id      out  1   squash IF/ID register to bubble
//  flush_ex      out  1   squash ID/EX register to bubble
//  mem_stall     out  1   freeze EX/MEM and later stages
//  wdt_err       out  1   sticky: memory wait reached 2^WDT_W-1 cycles
//  state         out  2   FSM state, for debug
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=RUN. All outputs 0; dnpc=0. Counters, pend_valid,
//   pend_pc, lu_cnt and wdt_err cleared. A reset during MWAIT discards any pending redirect.
//  lu_hit = ex_valid & ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd)
//   | (id_rs2_used & id_rs2==ex_rd)). This is combinational.
//  Priority in every state: memory wait > redirect > load-use.
//  States: RUN=0, LU=1, MWAIT=2, RDR=3.
//  Mutual exclusion: stall and dnpc_flag are never both 1 in a cycle. flush_id never
//   coincides with id_stall.
//  RUN:
//   - dmem_req & !dmem_ack: stall=id_stall=mem_stall=1 this cycle; next=MWAIT; wdt=1.
//   - else ex_br_taken: dnpc=ex_br_target, dnpc_flag=1, flush_id=flush_ex=1 this cycle
//     (fetch takes target at next edge); next=RUN.
//   - else lu_hit: stall=id_stall=flush_ex=1; lu_cnt=LU_STALL_CYCLES-1; next=LU if
//     lu_cnt>0, else RUN.
//  LU:
//   - Outputs: stall=id_stall=flush_ex=1; lu_cnt decrements each cycle; next=RUN when 0.
//   - ex_br_taken is ignored here (EX holds a bubble).
//   - A memory wait pre-empts LU: go to MWAIT with lu_cnt frozen.
//  MWAIT:
//   - Outputs: stall=id_stall=mem_stall=1 while !dmem_ack. All three deassert
//     combinationally in the dmem_ack cycle.
//   - wdt increments per cycle and saturates at 2^WDT_W-1; wdt_err sets when it reaches that.
//   - ex_br_taken while pend_valid=0: latch pend_pc=ex_br_target, pend_valid=1. Later
//     assertions are ignored (frozen pipeline re-presents the same branch).
//   - On dmem_ack: wdt=0. Next=RDR if pend_valid, else LU if lu_cnt>0, else RUN.
//  RDR (exactly 1 cycle):
//   - Outputs: dnpc=pend_pc, dnpc_flag=1, flush_id=flush_ex=1, stall=0.
//   - pend_valid cleared; lu_cnt cleared; next=RUN.
//  dnpc is 0 whenever dnpc_flag=0. wdt_err clears only on reset.
// TESTING
//  1 Load x5 in EX, ID add reads x5, LU_STALL_CYCLES=2 -> stall=flush_ex=1 for 2 cycles,
//    state 0->1->0.
//  2 Load in EX with rd=x0, ID reads x0 -> no stall; state stays 0.
//  3 ex_br_taken=1, target=0x0000_0040 in RUN -> same cycle dnpc=0x40, dnpc_flag=1,
//    flush_id=flush_ex=1, stall=0.
//  4 dmem_req 3 cycles before ack, branch to 0x80 in 2nd cycle -> stall=1 for 3 cycles;
//    then one RDR cycle with dnpc=0x80, dnpc_flag=1.
//  5 WDT_W=4, dmem_req held with no ack for 20 cycles -> wdt_err=1 from cycle 15;
//    stays 1 after ack.
//  6 reset_n=0 mid-MWAIT with pend_valid=1 -> next cycle state=0, all outputs 0,
//    no redirect issued.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use stalls,
// taken-branch redirects and data-memory wait states. A redirect seen during a wait is held.
module pipe_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int WDT_W           = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] dnpc,
  output logic        dnpc_flag,
  output logic        id_stall,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        mem_stall,
  output logic        wdt_err,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU    = 2'd1,
    MWAIT = 2'd2,
    RDR   = 2'd3
  } state_e;

  localparam logic [2:0]       LU_INIT = 3'(LU_STALL_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_MAX = '1;

  state_e           cur_state, nxt_state;
  logic [2:0]       lu_cnt, lu_cnt_nxt;
  logic [WDT_W-1:0] wdt, wdt_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [31:0]      pend_pc, pend_pc_nxt;
  logic             wdt_err_nxt;
  logic             lu_hit;
  logic             mem_wait;

  assign lu_hit = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign mem_wait = dmem_req & ~dmem_ack;
  assign state    = cur_state;

  always_comb begin
    nxt_state      = cur_state;
    lu_cnt_nxt     = lu_cnt;
    wdt_nxt        = wdt;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    wdt_err_nxt    = wdt_err;
    stall          = 1'b0;
    dnpc           = 32'd0;
    dnpc_flag      = 1'b0;
    id_stall       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    mem_stall      = 1'b0;

    case (cur_state)
      RUN, LU: begin
        if (mem_wait) begin
          // Entering a wait freezes lu_cnt so the remaining load-use cycles resume afterwards
          stall       = 1'b1;
          id_stall    = 1'b1;
          mem_stall   = 1'b1;
          wdt_nxt     = WDT_W'(1);
          wdt_err_nxt = wdt_err | (WDT_W'(1) == WDT_MAX);
          nxt_state   = MWAIT;
        end else if (cur_state == RUN) begin
          if (ex_br_taken) begin
            dnpc      = ex_br_target;
            dnpc_flag = 1'b1;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
          end else if (lu_hit) begin
            stall      = 1'b1;
            id_stall   = 1'b1;
            flush_ex   = 1'b1;
            lu_cnt_nxt = LU_INIT;
            nxt_state  = (LU_INIT != 3'd0) ? LU : RUN;
          end
        end else begin
          stall      = 1'b1;
          id_stall   = 1'b1;
          flush_ex   = 1'b1;
          lu_cnt_nxt = (lu_cnt != 3'd0) ? lu_cnt - 3'd1 : 3'd0;
          if (lu_cnt <= 3'd1) nxt_state = RUN;
        end
      end

      MWAIT: begin
        // Capture in the ack cycle too: the pipeline unfreezes then and the branch would be lost
        if (ex_br_taken && !pend_valid) begin
          pend_valid_nxt = 1'b1;
          pend_pc_nxt    = ex_br_target;
        end
        if (!dmem_ack) begin
          stall       = 1'b1;
          id_stall    = 1'b1;
          mem_stall   = 1'b1;
          wdt_nxt     = (wdt == WDT_MAX) ? wdt : wdt + WDT_W'(1);
          wdt_err_nxt = wdt_err | (wdt_nxt == WDT_MAX);
        end else begin
          wdt_nxt = '0;
          if (pend_valid_nxt)      nxt_state = RDR;
          else if (lu_cnt != 3'd0) nxt_state = LU;
          else                     nxt_state = RUN;
        end
      end

      RDR: begin
        dnpc           = pend_pc;
        dnpc_flag      = 1'b1;
        flush_id       = 1'b1;
        flush_ex       = 1'b1;
        pend_valid_nxt = 1'b0;
        lu_cnt_nxt     = 3'd0;
        nxt_state      = RUN;
      end

      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_state  <= RUN;
      lu_cnt     <= 3'd0;
      wdt        <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
      wdt_err    <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      lu_cnt     <= lu_cnt_nxt;
      wdt        <= wdt_nxt;
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
      wdt_err    <= wdt_err_nxt;
    end
  end

endmodule
